// File: rtl/aes_fsm_pkg.sv
// Shared definitions for the AES-128 encryption and decryption controllers.
// Contents:
//   enc_state_e    - controller states (IDLE, KEY_WAIT, INITIAL_ROUND, MID_ROUND,
//                    LAST_ROUND, DONE)
//   AES128_ROUNDS  - round count for AES-128
//   ROUND_IDX_W    - width of the round / key index
package aes_fsm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKeyWait,
    StInitialRound,
    StMidRound,
    StLastRound,
    StDone
  } enc_state_e;

  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned ROUND_IDX_W   = 4;

endpackage

// File: rtl/encryption_fsm_if.sv
// Control/handshake bundle between the encryption controller and its
// surroundings (host start, key-expansion handshake, datapath controls).
// Optional macro ENC_FSM_ABORT_EN adds the abort input.
// Modports:
//   master - controller side: consumes start/key_valid(/abort), drives
//            req_key, round_idx, mux_sel, state_ld, last_round, busy, done
//   slave  - host/datapath side, the mirror image
interface encryption_fsm_if;
  import aes_fsm_pkg::*;

  logic                   start;
  logic                   key_valid;
`ifdef ENC_FSM_ABORT_EN
  logic                   abort;
`endif
  logic                   req_key;
  logic [ROUND_IDX_W-1:0] round_idx;
  logic                   mux_sel;
  logic                   state_ld;
  logic                   last_round;
  logic                   busy;
  logic                   done;

  modport master (
`ifdef ENC_FSM_ABORT_EN
    input  abort,
`endif
    input  start,
    input  key_valid,
    output req_key,
    output round_idx,
    output mux_sel,
    output state_ld,
    output last_round,
    output busy,
    output done
  );

  modport slave (
`ifdef ENC_FSM_ABORT_EN
    output abort,
`endif
    output start,
    output key_valid,
    input  req_key,
    input  round_idx,
    input  mux_sel,
    input  state_ld,
    input  last_round,
    input  busy,
    input  done
  );

endinterface

// File: rtl/round_timer.sv
// Loadable down-counter with zero flag; times the datapath cycles of a round.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   clear      - synchronous clear (used for abort), below reset in priority
//   load       - load load_val (wins over dec)
//   dec        - decrement; holds at zero rather than wrapping
//   count      - current count
//   zero       - count == 0
module round_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic [Width-1:0] count,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/encryption_fsm.sv
// AES-128 encryption control FSM. Sequences the initial AddRoundKey, the
// NUM_ROUNDS-1 full rounds and the final round (no MixColumns), fetching round
// keys 0..NUM_ROUNDS in order through a req_key/key_valid handshake.
// Optional macro ENC_FSM_ABORT_EN: adds bus.abort, which returns any busy
// state to IDLE on the next edge (reset still takes priority).
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high reset
//   bus   - encryption_fsm_if.master (start, key_valid, [abort] in;
//           req_key, round_idx, mux_sel, state_ld, last_round, busy, done out)
module encryption_fsm
  import aes_fsm_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = AES128_ROUNDS,
  parameter int unsigned ROUND_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  encryption_fsm_if.master bus
);

  localparam int unsigned CycW = $clog2(ROUND_CYCLES + 1);
  localparam logic [ROUND_IDX_W-1:0] LastIdx = ROUND_IDX_W'(NUM_ROUNDS);
  localparam logic [CycW-1:0] CycInit = CycW'(ROUND_CYCLES - 1);

  enc_state_e             state_q;
  logic [ROUND_IDX_W-1:0] round_idx_q;
  logic [CycW-1:0]        cyc;
  logic                   cyc_zero;
  logic                   cyc_load;
  logic                   cyc_dec;
  logic                   in_round;
  logic                   abort_hit;

`ifdef ENC_FSM_ABORT_EN
  assign abort_hit = bus.abort && (state_q != StIdle);
`else
  assign abort_hit = 1'b0;
`endif

  assign in_round = (state_q == StMidRound) || (state_q == StLastRound);

  // Key 0 feeds the single-cycle initial round; all others start a timed round.
  assign cyc_load = (state_q == StKeyWait) && bus.key_valid && (round_idx_q != '0) && !abort_hit;
  assign cyc_dec  = in_round && (cyc != '0);

  round_timer #(
    .Width (CycW)
  ) u_round_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (abort_hit),
    .load     (cyc_load),
    .load_val (CycInit),
    .dec      (cyc_dec),
    .count    (cyc),
    .zero     (cyc_zero)
  );

  always_ff @(posedge clk) begin
    if (reset || abort_hit) begin
      state_q     <= StIdle;
      round_idx_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q     <= StKeyWait;
            round_idx_q <= '0;
          end
        end
        StKeyWait: begin
          if (bus.key_valid) begin
            if (round_idx_q == '0) begin
              state_q <= StInitialRound;
            end else if (round_idx_q == LastIdx) begin
              state_q <= StLastRound;
            end else begin
              state_q <= StMidRound;
            end
          end
        end
        StInitialRound: begin
          state_q     <= StKeyWait;
          round_idx_q <= ROUND_IDX_W'(1);
        end
        StMidRound: begin
          if (cyc_zero) begin
            state_q     <= StKeyWait;
            round_idx_q <= round_idx_q + ROUND_IDX_W'(1);
          end
        end
        StLastRound: begin
          if (cyc_zero) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q     <= StIdle;
          round_idx_q <= '0;
        end
        default: begin
          state_q     <= StIdle;
          round_idx_q <= '0;
        end
      endcase
    end
  end

  // Moore decode from registered state, index and cycle count.
  always_comb begin
    bus.busy       = (state_q != StIdle);
    bus.req_key    = (state_q == StKeyWait);
    bus.mux_sel    = in_round;
    bus.last_round = (state_q == StLastRound);
    bus.state_ld   = (state_q == StInitialRound) || (in_round && cyc_zero);
    bus.done       = (state_q == StDone);
    bus.round_idx  = round_idx_q;
  end

endmodule

// File: tb/tb_encryption_fsm.sv
// Self-checking bench for encryption_fsm. A reference trace is generated per
// run from the protocol rules (key fetch per round, stalls, round lengths) and
// replayed cycle by cycle against the DUT outputs.
module tb_encryption_fsm;
  import aes_fsm_pkg::*;

  localparam int unsigned NR = 10;
  localparam int unsigned RC = 3;
  localparam int unsigned BASE_LAT = 3 + NR * (1 + RC);

  logic clk = 1'b0;
  logic reset;

  encryption_fsm_if bus();

  encryption_fsm #(
    .NUM_ROUNDS   (NR),
    .ROUND_CYCLES (RC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       reset;
    bit       abort;
    bit       start;
    bit       key_valid;
    bit       run_start;
    bit       idx_care;
    bit [3:0] round_idx;
    bit       busy;
    bit       req_key;
    bit       mux_sel;
    bit       state_ld;
    bit       last_round;
    bit       done;
  } step_t;

  step_t trace[$];
  int    exp_lat[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_idle(input int n, input bit noisy);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s = '0;
      s.key_valid = noisy ? rbit() : 1'b0;
      trace.push_back(s);
    end
  endtask

  // One full encryption: start cycle, key fetch (with stalls) per round, round
  // body, done. Non-noisy runs tie key_valid high outside stalls.
  task automatic push_run(input int stall_round, input int stall_len, input bit rand_stall,
                          input bit noisy);
    step_t s;
    int    st;
    int    total = 0;
    s = '0;
    s.start = 1'b1;
    s.run_start = 1'b1;
    s.key_valid = noisy ? rbit() : 1'b1;
    trace.push_back(s);
    for (int r = 0; r <= int'(NR); r++) begin
      st = rand_stall ? int'($urandom_range(0, 2)) : ((r == stall_round) ? stall_len : 0);
      total += st;
      for (int i = 0; i <= st; i++) begin
        s = '0;
        s.busy = 1'b1;
        s.req_key = 1'b1;
        s.idx_care = 1'b1;
        s.round_idx = 4'(r);
        s.key_valid = (i == st);
        s.start = noisy ? rbit() : 1'b0;
        trace.push_back(s);
      end
      if (r == 0) begin
        s = '0;
        s.busy = 1'b1;
        s.state_ld = 1'b1;
        s.idx_care = 1'b1;
        s.key_valid = noisy ? rbit() : 1'b1;
        s.start = noisy ? rbit() : 1'b0;
        trace.push_back(s);
      end else begin
        for (int c = int'(RC) - 1; c >= 0; c--) begin
          s = '0;
          s.busy = 1'b1;
          s.mux_sel = 1'b1;
          s.last_round = (r == int'(NR));
          s.state_ld = (c == 0);
          s.idx_care = 1'b1;
          s.round_idx = 4'(r);
          s.key_valid = noisy ? rbit() : 1'b1;
          s.start = noisy ? rbit() : 1'b0;
          trace.push_back(s);
        end
      end
    end
    s = '0;
    s.busy = 1'b1;
    s.done = 1'b1;
    s.idx_care = 1'b1;
    s.round_idx = 4'(NR);
    s.key_valid = noisy ? rbit() : 1'b1;
    s.start = noisy ? rbit() : 1'b0;
    trace.push_back(s);
    exp_lat.push_back(int'(BASE_LAT) + total);
  endtask

  // Cut the last pushed run (starting at base) after cycle `at`, killing it
  // there with reset or abort; the following cycle must be fully idle.
  task automatic cut_run(input int base, input int at, input bit use_abort);
    step_t s;
    while (trace.size() > base + at + 1) void'(trace.pop_back());
    if (use_abort) trace[base + at].abort = 1'b1;
    else trace[base + at].reset = 1'b1;
    void'(exp_lat.pop_back());
    s = '0;
    s.idx_care = 1'b1;
    trace.push_back(s);
  endtask

  // Called #1 after a rising edge; returns at the same phase.
  task automatic play();
    step_t       s;
    logic [31:0] obs;
    logic [31:0] exp;
    int          start_idx = 0;
    int          ld_cnt = 0;
    int          dones = 0;
    int          exp_dones = 0;
    int          lat;
    foreach (trace[i]) if (trace[i].done) exp_dones++;
    for (int k = 0; k < trace.size(); k++) begin
      s = trace[k];
      reset = s.reset;
      bus.start = s.start;
      bus.key_valid = s.key_valid;
`ifdef ENC_FSM_ABORT_EN
      bus.abort = s.abort;
`endif
      if (s.run_start) begin
        start_idx = k;
        ld_cnt = 0;
      end
      @(negedge clk);
      obs = {22'd0, bus.busy, bus.req_key, bus.mux_sel, bus.state_ld, bus.last_round, bus.done,
             s.idx_care ? bus.round_idx : 4'h0};
      exp = {22'd0, s.busy, s.req_key, s.mux_sel, s.state_ld, s.last_round, s.done,
             s.idx_care ? s.round_idx : 4'h0};
      check_eq($sformatf("step%0d{busy,req,mux,ld,last,done,idx}", k), obs, exp);
      if (bus.state_ld) ld_cnt++;
      if (bus.done) begin
        dones++;
        lat = (exp_lat.size() > 0) ? exp_lat.pop_front() : -1;
        check_eq("done_latency", 32'(k - start_idx), 32'(lat));
        check_eq("state_ld_count", 32'(ld_cnt), 32'(NR + 1));
      end
      @(posedge clk);
      #1;
    end
    check_eq("done_count", 32'(dones), 32'(exp_dones));
    check_eq("runs_left", 32'(exp_lat.size()), 32'd0);
    exp_lat.delete();
    trace.delete();
  endtask

  int base;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.key_valid = 1'b0;
`ifdef ENC_FSM_ABORT_EN
    bus.abort = 1'b0;
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset_outputs",
             {bus.busy, bus.req_key, bus.mux_sel, bus.state_ld, bus.last_round, bus.done,
              bus.round_idx}, 32'd0);
    @(posedge clk);
    #1;

    // Nominal run, key_valid tied high.
    push_idle(1, 1'b0);
    push_run(-1, 0, 1'b0, 1'b0);
    play();

    // Five-cycle key stall on round 4.
    push_run(4, 5, 1'b0, 1'b0);
    play();

    // Stray starts at cycles 10 and 43, then back-to-back run at cycle 44.
    push_run(-1, 0, 1'b0, 1'b0);
    trace[10].start = 1'b1;
    trace[43].start = 1'b1;
    push_run(-1, 0, 1'b0, 1'b0);
    push_idle(2, 1'b0);
    play();

    // Reset at cycle 20 aborts the run without done.
    base = 0;
    push_run(-1, 0, 1'b0, 1'b0);
    cut_run(base, 20, 1'b0);
    push_idle(3, 1'b0);
    push_run(-1, 0, 1'b0, 1'b0);
    play();

    // Randomized runs: random stalls, stray start/key_valid, random gaps.
    for (int n = 0; n < 6; n++) begin
      push_run(-1, 0, 1'b1, 1'b1);
      push_idle(int'($urandom_range(0, 3)), 1'b1);
    end
    play();

`ifdef ENC_FSM_ABORT_EN
    // Abort at cycle 15, then abort together with start while idle.
    base = 0;
    push_run(-1, 0, 1'b0, 1'b0);
    cut_run(base, 15, 1'b1);
    push_idle(2, 1'b0);
    base = trace.size();
    push_run(-1, 0, 1'b0, 1'b0);
    trace[base].abort = 1'b1;
    play();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encryption_fsm.md
Name: encryption_fsm

Overview:
- Control FSM for the AES-128 encryption datapath; forward-direction counterpart of the decryption controller.
- Sequences the initial AddRoundKey, NUM_ROUNDS-1 full rounds and a final round without MixColumns.
- Requests round keys in ascending order (0..NUM_ROUNDS) from the key-expansion block through a req/valid handshake.
- Drives the datapath input mux, state-register load, last-round select and the done pulse.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; round_idx spans 0..NUM_ROUNDS.
- ROUND_CYCLES, 3, datapath cycles per full or last round (>=1).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin encryption; sampled only in IDLE
- key_valid  input  1  key-expansion block presents the key for round_idx
- req_key  output  1  level request for the round key indexed by round_idx
- round_idx  output  4  current round or key index
- mux_sel  output  1  0 = plaintext into state path, 1 = round feedback
- state_ld  output  1  load the datapath state register this cycle
- last_round  output  1  bypass MixColumns
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when ciphertext is valid

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (reset).
- Reset: all outputs 0 (round_idx=0, busy=0, done=0, req_key=0, mux_sel=0, state_ld=0, last_round=0); state=IDLE; cycle counter cyc=0. Reset asserted mid-operation aborts on the next edge with no done.
- States: IDLE, KEY_WAIT, INITIAL_ROUND, MID_ROUND, LAST_ROUND, DONE. Outputs are decoded from registered state, round_idx and cyc.
- IDLE: start=1 -> KEY_WAIT, round_idx<=0. start is ignored in every other state.
- KEY_WAIT: req_key=1, held until key_valid is sampled high.
  - key_valid with round_idx==0 -> INITIAL_ROUND.
  - key_valid with round_idx==NUM_ROUNDS -> LAST_ROUND, cyc<=ROUND_CYCLES-1.
  - key_valid otherwise -> MID_ROUND, cyc<=ROUND_CYCLES-1.
  - key_valid outside KEY_WAIT is ignored.
- INITIAL_ROUND: 1 cycle; mux_sel=0, state_ld=1; then round_idx<=1 -> KEY_WAIT.
- MID_ROUND: mux_sel=1; cyc decrements each cycle. At cyc==0: state_ld=1, round_idx<=round_idx+1 -> KEY_WAIT.
- LAST_ROUND: mux_sel=1, last_round=1; cyc decrements each cycle. At cyc==0: state_ld=1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. A start in the same cycle is ignored, because it is not sampled in DONE.
- state_ld is never high outside INITIAL_ROUND and the cyc==0 cycles above.
- Latency with key_valid always high: done asserts in cycle 3+NUM_ROUNDS*(1+ROUND_CYCLES) after start is sampled. Default = 43. Each KEY_WAIT stall cycle adds 1.
- Arithmetic: round_idx is 4-bit, never exceeds NUM_ROUNDS and never wraps. cyc is $clog2(ROUND_CYCLES+1) bits and never underflows.

Optional Feature:
- Macro: ENC_FSM_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 in any non-IDLE state -> IDLE on the next edge.
  - Outputs return to reset values; no done pulse.
  - abort has priority over all other transitions; reset has priority over abort.
  - abort in IDLE has no effect.
- Undefined: no abort port; behaviour as above.

Decomposition:
- aes_fsm_pkg:
  - enc_state_e enum (the six states).
  - Constants AES128_ROUNDS=10 and ROUND_IDX_W=4.
  - Shared with the decryption controller.
- Sub-module round_timer: loadable down-counter with a zero flag, driving cyc. It is natural to reuse in the decryption FSM. All other logic stays in encryption_fsm.

Test Plan:
- Reset then start=1 for 1 cycle, key_valid tied 1 -> round_idx steps 0,1..10; state_ld pulses exactly 11 times; last_round high only during round 10; done high for exactly one cycle at cycle 43; busy falls the following cycle.
- key_valid delayed 5 cycles on round 4 only -> req_key held for those 5 cycles with round_idx=4 and no state_ld; done at cycle 48.
- start pulsed at cycles 10 and 43 of a run -> ignored, no restart, single done. start at cycle 44 (IDLE) -> new run begins.
- reset asserted for 1 cycle at cycle 20 -> next cycle all outputs 0, state IDLE, no done, round_idx=0.
- Two back-to-back runs, start asserted the cycle after done -> second run identical in timing to the first (done 43 cycles after its start).
- With ENC_FSM_ABORT_EN: abort at cycle 15 -> IDLE next cycle, busy=0, no done. abort and start together in IDLE -> run starts normally.
